tlul_reg_arbiter: RTL and testbench

- Shares one downstream register-interface target (register file or peripheral decode) between NumReq upstream register-interface requesters.
- Each requester is normally the register side of its own TL-UL register adapter: one-cycle re/we pulse, then waits for ack.
- Captures each request pulse into a per-requester pending slot and grants pending slots round-robin. Issues each request downstream, waits for the target ack or a timeout, then returns a one-cycle ack with rdata and error to the originating requester.

---
 rtl/tlul_reg_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_tlul_reg_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_reg_arbiter.sv
// Round-robin arbiter sharing one downstream register target between NumReq
// register-interface requesters, with per-requester pending slots and a WAIT timeout.
module tlul_reg_arbiter #(
    parameter int NumReq        = 2,
    parameter int RegAw         = 8,
    parameter int RegDw         = 32,
    parameter int TimeoutCycles = 256,
    localparam int RegBw        = RegDw / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_re_i,
    input  logic [NumReq-1:0]        req_we_i,
    input  logic [NumReq*RegAw-1:0]  req_addr_i,
    input  logic [NumReq*RegDw-1:0]  req_wdata_i,
    input  logic [NumReq*RegBw-1:0]  req_be_i,
    output logic [RegDw-1:0]         req_rdata_o,
    output logic [NumReq-1:0]        req_ack_o,
    output logic [NumReq-1:0]        req_error_o,
    output logic                     reg_re_o,
    output logic                     reg_we_o,
    output logic [RegAw-1:0]         reg_addr_o,
    output logic [RegDw-1:0]         reg_wdata_o,
    output logic [RegBw-1:0]         reg_be_o,
    input  logic [RegDw-1:0]         reg_rdata_i,
    input  logic                     reg_ack_i,
    input  logic                     reg_error_i,
    output logic                     busy_o
);

    localparam int GW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CW = $clog2(TimeoutCycles + 1);
    localparam logic [NumReq-1:0] ONE_HOT0 = {{(NumReq-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                 r_state;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_rr;
    logic [CW-1:0]          r_cnt;
    logic                   r_op_we;
    logic                   r_reg_re;
    logic                   r_reg_we;
    logic [RegAw-1:0]       r_reg_addr;
    logic [RegDw-1:0]       r_reg_wdata;
    logic [RegBw-1:0]       r_reg_be;
    logic [RegDw-1:0]       r_req_rdata;
    logic [NumReq-1:0]      r_req_ack;
    logic [NumReq-1:0]      r_req_error;

    logic [NumReq-1:0]          w_pending;
    logic [NumReq-1:0]          w_clear;
    logic [NumReq-1:0]          w_grant_oh;
    logic [NumReq-1:0]          w_slot_we;
    logic [NumReq*RegAw-1:0]    w_slot_addr;
    logic [NumReq*RegDw-1:0]    w_slot_wdata;
    logic [NumReq*RegBw-1:0]    w_slot_be;
    logic [GW-1:0]              w_arb;
    logic [RegDw-1:0]           w_cap_rdata;
    int                         w_idx;

    assign w_grant_oh  = ONE_HOT0 << r_grant;
    assign w_clear     = (r_state == ST_RESP) ? w_grant_oh : '0;
    assign w_cap_rdata = r_op_we ? '0 : reg_rdata_i;

    // Clearing and re-capturing in the same RESP cycle lets a requester
    // queue its next access without losing a cycle.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_slot
        logic               r_pending;
        logic               r_we;
        logic [RegAw-1:0]   r_addr;
        logic [RegDw-1:0]   r_wdata;
        logic [RegBw-1:0]   r_be;
        logic               w_pulse;

        assign w_pulse = req_re_i[gi] | req_we_i[gi];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_pending <= 1'b0;
                r_we      <= 1'b0;
                r_addr    <= '0;
                r_wdata   <= '0;
                r_be      <= '0;
            end else if (w_pulse && (!r_pending || w_clear[gi])) begin
                r_pending <= 1'b1;
                r_we      <= req_we_i[gi];
                r_addr    <= req_addr_i[gi*RegAw +: RegAw];
                r_wdata   <= req_wdata_i[gi*RegDw +: RegDw];
                r_be      <= req_be_i[gi*RegBw +: RegBw];
            end else if (w_clear[gi]) begin
                r_pending <= 1'b0;
            end
        end

        assign w_pending[gi]                   = r_pending;
        assign w_slot_we[gi]                   = r_we;
        assign w_slot_addr[gi*RegAw +: RegAw]  = r_addr;
        assign w_slot_wdata[gi*RegDw +: RegDw] = r_wdata;
        assign w_slot_be[gi*RegBw +: RegBw]    = r_be;
    end

    // Scan offsets high to low so the nearest pending slot at or above r_rr wins.
    always_comb begin
        w_arb = r_rr;
        w_idx = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NumReq) begin
                w_idx = w_idx - NumReq;
            end
            if (w_pending[w_idx[GW-1:0]]) begin
                w_arb = GW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr        <= '0;
            r_cnt       <= '0;
            r_op_we     <= 1'b0;
            r_reg_re    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_be    <= '0;
            r_req_rdata <= '0;
            r_req_ack   <= '0;
            r_req_error <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_grant     <= w_arb;
                        r_op_we     <= w_slot_we[w_arb];
                        r_reg_re    <= ~w_slot_we[w_arb];
                        r_reg_we    <= w_slot_we[w_arb];
                        r_reg_addr  <= w_slot_addr[w_arb*RegAw +: RegAw];
                        r_reg_wdata <= w_slot_wdata[w_arb*RegDw +: RegDw];
                        r_reg_be    <= w_slot_be[w_arb*RegBw +: RegBw];
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_reg_re <= 1'b0;
                    r_reg_we <= 1'b0;
                    if (reg_ack_i) begin
                        r_req_rdata <= w_cap_rdata;
                        r_req_ack   <= w_grant_oh;
                        r_req_error <= reg_error_i ? w_grant_oh : '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt   <= CW'(1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (reg_ack_i) begin
                        r_req_rdata <= w_cap_rdata;
                        r_req_ack   <= w_grant_oh;
                        r_req_error <= reg_error_i ? w_grant_oh : '0;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == CW'(TimeoutCycles)) begin
                        r_req_rdata <= '0;
                        r_req_ack   <= w_grant_oh;
                        r_req_error <= w_grant_oh;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_req_ack   <= '0;
                    r_req_error <= '0;
                    r_rr        <= (r_grant == GW'(NumReq - 1)) ? '0 : r_grant + GW'(1);
                    r_cnt       <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_rdata_o = r_req_rdata;
    assign req_ack_o   = r_req_ack;
    assign req_error_o = r_req_error;
    assign reg_re_o    = r_reg_re;
    assign reg_we_o    = r_reg_we;
    assign reg_addr_o  = r_reg_addr;
    assign reg_wdata_o = r_reg_wdata;
    assign reg_be_o    = r_reg_be;
    assign busy_o      = (r_state != ST_IDLE) | (|w_pending);

endmodule

// File: tb/tb_tlul_reg_arbiter.sv
// Directed bench for tlul_reg_arbiter with three requesters and a short timeout;
// the target is either an instant-ack model or driven cycle by cycle.
module tb_tlul_reg_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_re_i = '0;
    logic [N-1:0]      req_we_i = '0;
    logic [N*AW-1:0]   req_addr_i = '0;
    logic [N*DW-1:0]   req_wdata_i = '0;
    logic [N*BW-1:0]   req_be_i = '0;
    logic [DW-1:0]     req_rdata_o;
    logic [N-1:0]      req_ack_o;
    logic [N-1:0]      req_error_o;
    logic              reg_re_o;
    logic              reg_we_o;
    logic [AW-1:0]     reg_addr_o;
    logic [DW-1:0]     reg_wdata_o;
    logic [BW-1:0]     reg_be_o;
    logic [DW-1:0]     reg_rdata_i;
    logic              reg_ack_i;
    logic              reg_error_i;
    logic              busy_o;

    logic              tgt_auto = 1'b1;
    logic              tb_ack = 1'b0;
    logic              tb_err = 1'b0;
    logic [DW-1:0]     tb_rdata = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign reg_ack_i   = tgt_auto ? (reg_re_o | reg_we_o) : tb_ack;
    assign reg_error_i = tb_err;
    assign reg_rdata_i = tb_rdata;

    tlul_reg_arbiter #(
        .NumReq(N), .RegAw(AW), .RegDw(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_re_i(req_re_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .req_rdata_o(req_rdata_o), .req_ack_o(req_ack_o), .req_error_o(req_error_o),
        .reg_re_o(reg_re_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o),
        .reg_rdata_i(reg_rdata_i), .reg_ack_i(reg_ack_i), .reg_error_i(reg_error_i),
        .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({req_ack_o, req_error_o, reg_re_o, reg_we_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: ack=%b err=%b re=%b we=%b busy=%b, want all 0",
                     req_ack_o, req_error_o, reg_re_o, reg_we_o, busy_o);
        end
        total++;
        if ({req_rdata_o, reg_addr_o, reg_wdata_o, reg_be_o} !== '0) begin
            bad++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h, want 0",
                     req_rdata_o, reg_addr_o, reg_wdata_o, reg_be_o);
        end
        $display("txn reset done");
    endtask

    task automatic test_single_read();
        tgt_auto = 1'b1; tb_err = 1'b0; tb_rdata = 32'hDEADBEEF;
        req_addr_i[0 +: AW] = 8'h10;
        req_re_i = 3'b001;
        tick();
        req_re_i = '0;
        total++;
        if (busy_o !== 1'b1 || reg_re_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_t1: busy=%b re=%b, want busy=1 re=0", busy_o, reg_re_o);
        end
        tick();
        total++;
        if (reg_re_o !== 1'b1 || reg_we_o !== 1'b0 || reg_addr_o !== 8'h10) begin
            bad++;
            $display("FAIL rd_issue: re=%b we=%b addr=%h, want 1 0 10", reg_re_o, reg_we_o, reg_addr_o);
        end
        tick();
        total++;
        if (req_ack_o !== 3'b001 || req_rdata_o !== 32'hDEADBEEF || req_error_o !== 3'b000) begin
            bad++;
            $display("FAIL rd_resp: ack=%b rdata=%h err=%b, want 001 deadbeef 000",
                     req_ack_o, req_rdata_o, req_error_o);
        end
        tick();
        total++;
        if (req_ack_o !== 3'b000 || req_rdata_o !== 32'hDEADBEEF || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_after: ack=%b rdata=%h busy=%b, want 000 deadbeef 0",
                     req_ack_o, req_rdata_o, busy_o);
        end
        $display("txn single read req0 addr=10 rdata=%h", req_rdata_o);
    endtask

    task automatic test_simul_writes();
        do_reset();
        tgt_auto = 1'b1; tb_err = 1'b0; tb_rdata = 32'h55AA55AA;
        req_addr_i[0 +: AW]  = 8'h20; req_wdata_i[0 +: DW]  = 32'h11112222; req_be_i[0 +: BW]  = 4'hF;
        req_addr_i[AW +: AW] = 8'h24; req_wdata_i[DW +: DW] = 32'h33334444; req_be_i[BW +: BW] = 4'h3;
        req_we_i = 3'b011;
        tick();
        req_we_i = '0;
        tick();
        total++;
        if (reg_we_o !== 1'b1 || reg_re_o !== 1'b0 || reg_addr_o !== 8'h20 ||
            reg_wdata_o !== 32'h11112222 || reg_be_o !== 4'hF) begin
            bad++;
            $display("FAIL wr0_issue: we=%b re=%b addr=%h wdata=%h be=%h, want 1 0 20 11112222 f",
                     reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, reg_be_o);
        end
        tick();
        total++;
        if (req_ack_o !== 3'b001 || req_rdata_o !== 32'h0 || req_error_o !== 3'b000) begin
            bad++;
            $display("FAIL wr0_resp: ack=%b rdata=%h err=%b, want 001 0 000", req_ack_o, req_rdata_o, req_error_o);
        end
        tick();
        total++;
        if (req_ack_o !== 3'b000 || reg_we_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL wr_gap: ack=%b we=%b busy=%b, want 000 0 1", req_ack_o, reg_we_o, busy_o);
        end
        tick();
        total++;
        if (reg_we_o !== 1'b1 || reg_addr_o !== 8'h24 || reg_wdata_o !== 32'h33334444 || reg_be_o !== 4'h3) begin
            bad++;
            $display("FAIL wr1_issue: we=%b addr=%h wdata=%h be=%h, want 1 24 33334444 3",
                     reg_we_o, reg_addr_o, reg_wdata_o, reg_be_o);
        end
        tick();
        total++;
        if (req_ack_o !== 3'b010 || req_error_o !== 3'b000) begin
            bad++;
            $display("FAIL wr1_resp: ack=%b err=%b, want 010 000", req_ack_o, req_error_o);
        end
        tick();
        $display("txn simultaneous writes req0 then req1 done");
    endtask

    task automatic test_fairness();
        int exp_idx;
        int got_idx;
        int last_cyc;
        int guard;
        do_reset();
        tgt_auto = 1'b1; tb_err = 1'b0; tb_rdata = 32'hCAFEF00D;
        for (int i = 0; i < N; i++) req_addr_i[i*AW +: AW] = AW'(8'h40 + i);
        req_re_i = 3'b111;
        tick();
        req_re_i = '0;
        last_cyc = 0;
        for (int n = 0; n < 9; n++) begin
            guard = 0;
            while (req_ack_o === '0 && guard < 20) begin
                tick();
                guard++;
            end
            exp_idx = n % N;
            got_idx = -1;
            for (int i = 0; i < N; i++) if (req_ack_o === (3'b001 << i)) got_idx = i;
            total++;
            if (got_idx != exp_idx) begin
                bad++;
                $display("FAIL fair_grant%0d: ack=%b, want requester %0d", n, req_ack_o, exp_idx);
            end
            if (n > 0) begin
                total++;
                if (cyc - last_cyc != 3) begin
                    bad++;
                    $display("FAIL fair_gap%0d: %0d cycles between acks, want 3", n, cyc - last_cyc);
                end
            end
            $display("txn fairness ack %0d -> requester %0d at cycle %0d", n, got_idx, cyc);
            last_cyc = cyc;
            if (got_idx >= 0) req_re_i = 3'b001 << got_idx;
            tick();
            req_re_i = '0;
        end
        guard = 0;
        while (busy_o === 1'b1 && guard < 30) begin
            tick();
            guard++;
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL fair_drain: busy=%b after %0d cycles, want 0", busy_o, guard);
        end
    endtask

    task automatic test_timeout();
        tgt_auto = 1'b0; tb_ack = 1'b0; tb_err = 1'b0; tb_rdata = 32'h99998888;
        req_addr_i[2*AW +: AW] = 8'h30;
        req_re_i = 3'b100;
        tick();
        req_re_i = '0;
        tick();
        total++;
        if (reg_re_o !== 1'b1 || reg_addr_o !== 8'h30) begin
            bad++;
            $display("FAIL to_issue: re=%b addr=%h, want 1 30", reg_re_o, reg_addr_o);
        end
        for (int w = 1; w <= TO; w++) begin
            tick();
            total++;
            if (reg_re_o !== 1'b0 || req_ack_o !== 3'b000 || reg_addr_o !== 8'h30) begin
                bad++;
                $display("FAIL to_wait%0d: re=%b ack=%b addr=%h, want 0 000 30", w, reg_re_o, req_ack_o, reg_addr_o);
            end
        end
        tick();
        tb_ack = 1'b1;
        total++;
        if (req_ack_o !== 3'b100 || req_error_o !== 3'b100 || req_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL to_resp: ack=%b err=%b rdata=%h, want 100 100 0", req_ack_o, req_error_o, req_rdata_o);
        end
        $display("txn timeout req2 addr=30 err=%b rdata=%h", req_error_o, req_rdata_o);
        tick();
        tick();
        tb_ack = 1'b0;
        total++;
        if (req_ack_o !== 3'b000 || req_error_o !== 3'b000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL to_stray: ack=%b err=%b busy=%b, want 000 000 0", req_ack_o, req_error_o, busy_o);
        end
    endtask

    task automatic test_target_error();
        tgt_auto = 1'b0; tb_ack = 1'b0; tb_err = 1'b0; tb_rdata = 32'h0BADF00D;
        req_addr_i[AW +: AW] = 8'h44;
        req_re_i = 3'b010;
        tick();
        req_re_i = '0;
        tick();
        tick();
        tick();
        tick();
        tb_ack = 1'b1; tb_err = 1'b1;
        total++;
        if (req_ack_o !== 3'b000) begin
            bad++;
            $display("FAIL err_wait: ack=%b, want 000", req_ack_o);
        end
        tick();
        tb_ack = 1'b0; tb_err = 1'b0;
        total++;
        if (req_ack_o !== 3'b010 || req_error_o !== 3'b010 || req_rdata_o !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL err_resp: ack=%b err=%b rdata=%h, want 010 010 0badf00d",
                     req_ack_o, req_error_o, req_rdata_o);
        end
        $display("txn target error req1 addr=44 err=%b rdata=%h", req_error_o, req_rdata_o);
        tick();
        total++;
        if (req_ack_o !== 3'b000 || req_error_o !== 3'b000) begin
            bad++;
            $display("FAIL err_after: ack=%b err=%b, want 000 000", req_ack_o, req_error_o);
        end
    endtask

    task automatic test_reset_midop();
        int stale;
        tgt_auto = 1'b0; tb_ack = 1'b0; tb_err = 1'b0;
        req_addr_i[0 +: AW] = 8'h60; req_wdata_i[0 +: DW] = 32'hA0A0A0A0; req_be_i[0 +: BW] = 4'hC;
        req_we_i = 3'b001;
        tick();
        req_we_i = '0;
        req_re_i = 3'b010;
        tick();
        req_re_i = '0;
        tick();
        tick();
        #1;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({req_ack_o, req_error_o, reg_re_o, reg_we_o, busy_o} !== '0 ||
            {req_rdata_o, reg_addr_o, reg_wdata_o, reg_be_o} !== '0) begin
            bad++;
            $display("FAIL rst_async: ack=%b re=%b we=%b busy=%b rdata=%h addr=%h wdata=%h be=%h, want all 0",
                     req_ack_o, reg_re_o, reg_we_o, busy_o, req_rdata_o, reg_addr_o, reg_wdata_o, reg_be_o);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tb_ack = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            tb_ack = 1'b0;
            if (req_ack_o !== 3'b000 || busy_o !== 1'b0 || reg_re_o !== 1'b0 || reg_we_o !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL rst_stale: %0d cycles with ack/busy/strobe after reset, want 0", stale);
        end
        tgt_auto = 1'b1; tb_rdata = 32'h12345678;
        req_addr_i[0 +: AW] = 8'h50;
        req_re_i = 3'b001;
        tick();
        req_re_i = '0;
        tick();
        total++;
        if (reg_re_o !== 1'b1 || reg_addr_o !== 8'h50) begin
            bad++;
            $display("FAIL rst_fresh_issue: re=%b addr=%h, want 1 50", reg_re_o, reg_addr_o);
        end
        tick();
        total++;
        if (req_ack_o !== 3'b001 || req_rdata_o !== 32'h12345678 || req_error_o !== 3'b000) begin
            bad++;
            $display("FAIL rst_fresh_resp: ack=%b rdata=%h err=%b, want 001 12345678 000",
                     req_ack_o, req_rdata_o, req_error_o);
        end
        $display("txn fresh read after reset rdata=%h", req_rdata_o);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simul_writes();
        test_fairness();
        test_timeout();
        test_target_error();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
